// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path: digit codes, converter FSM
// encodings and segment patterns used by both the converter and the scan driver.
package seg_pkg;

    localparam int BCD_W = 4;

    // Code the scan driver renders as all segments off
    localparam logic [BCD_W-1:0] DIGIT_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seg_state_t;

    // Active-high segment patterns, bit order {dp, g, f, e, d, c, b, a}
    localparam logic [7:0] SEG_NUM0 = 8'h3F;
    localparam logic [7:0] SEG_NUM1 = 8'h06;
    localparam logic [7:0] SEG_NUM2 = 8'h5B;
    localparam logic [7:0] SEG_NUM3 = 8'h4F;
    localparam logic [7:0] SEG_NUM4 = 8'h66;
    localparam logic [7:0] SEG_NUM5 = 8'h6D;
    localparam logic [7:0] SEG_NUM6 = 8'h7D;
    localparam logic [7:0] SEG_NUM7 = 8'h07;
    localparam logic [7:0] SEG_NUM8 = 8'h7F;
    localparam logic [7:0] SEG_NUM9 = 8'h6F;
    localparam logic [7:0] SEG_NONE = 8'h00;

endpackage

// File: rtl/seg_bcd_add3.sv
// Single-digit double-dabble correction: add 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal position.
module seg_bcd_add3
    import seg_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [BCD_W-1:0] o_digit
);

    assign o_digit = (i_digit >= BCD_W'(5)) ? i_digit + BCD_W'(3) : i_digit;

endmodule

// File: rtl/seg_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD converter feeding the dynamic scan driver.
// Optional macro SEG_LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_bin2bcd
    import seg_pkg::*;
#(
    parameter int BIN_W   = 14,
    parameter int DIG_N   = 4,
    parameter int MAX_VAL = 9999
)
(
    input  logic                   sclk,
    input  logic                   s_rst_n,
    input  logic                   start,
    input  logic [BIN_W-1:0]       bin_in,
    output logic                   busy,
    output logic                   done,
    output logic [BCD_W*DIG_N-1:0] bcd_out,
    output logic                   ovf
);

    localparam int ACC_W = BCD_W * DIG_N;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);
    localparam logic [BIN_W-1:0] MAX_BIN    = BIN_W'(MAX_VAL);

    seg_state_t       r_state;
    logic [BIN_W-1:0] r_sreg;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_pend;

    logic [ACC_W-1:0] w_adj;
    logic [ACC_W-1:0] w_result;

    genvar g;
    generate
        for (g = 0; g < DIG_N; g++) begin : g_add3
            seg_bcd_add3 u_add3 (
                .i_digit (r_acc[g*BCD_W +: BCD_W]),
                .o_digit (w_adj[g*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // Final display value: overflow blanks everything, otherwise optional leading-zero blanking
    always_comb begin
        w_result = r_acc;
`ifdef SEG_LEAD_ZERO_BLANK_EN
        begin : blk_lead
            logic w_lead;
            w_lead = 1'b1;
            for (int i = DIG_N - 1; i > 0; i--) begin
                if (w_lead && (r_acc[i*BCD_W +: BCD_W] == '0))
                    w_result[i*BCD_W +: BCD_W] = DIGIT_BLANK;
                else
                    w_lead = 1'b0;
            end
        end
`endif
        if (r_ovf_pend)
            w_result = {DIG_N{DIGIT_BLANK}};
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state    <= IDLE;
            r_sreg     <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd_out    <= '0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sreg     <= bin_in;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= (bin_in > MAX_BIN);
                        busy       <= 1'b1;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Correct every digit, then shift the next binary MSB into the units digit
                    r_acc  <= {w_adj[ACC_W-2:0], r_sreg[BIN_W-1]};
                    r_sreg <= {r_sreg[BIN_W-2:0], 1'b0};
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_SHIFT)
                        r_state <= DONE;
                end
                DONE: begin
                    bcd_out <= w_result;
                    ovf     <= r_ovf_pend;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_bin2bcd.sv
// Scoreboard bench for seg_bin2bcd: expected results are queued at acceptance and
// compared, with latency and spacing, when done pulses.
module tb_seg_bin2bcd;

    localparam int LAT = 15;

    logic        sclk    = 1'b0;
    logic        s_rst_n = 1'b0;
    logic        start   = 1'b0;
    logic [13:0] bin_in  = '0;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        ovf;

    seg_bin2bcd #(.BIN_W(14), .DIG_N(4), .MAX_VAL(9999)) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    always #10 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    typedef struct {
        logic [16:0] exp;
        int          acc;
    } sb_t;
    sb_t sbq[$];

    int n_chk = 0;
    int n_err = 0;
    int last_done = -1;
    bit spacing_chk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: decimal digits by division, then display rules
    function automatic logic [16:0] model(input int v);
        logic [15:0] r;
        int t;
        bit lead;
        if (v > 9999) return {1'b1, 16'hFFFF};
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        lead = 1'b1;
`ifdef SEG_LEAD_ZERO_BLANK_EN
        for (int i = 3; i > 0; i--) begin
            if (lead && r[i*4 +: 4] == 4'h0) r[i*4 +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return {1'b0, r};
    endfunction

    always @(negedge sclk) begin
        sb_t e;
        if (s_rst_n && done) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("bcd_out", {16'd0, bcd_out}, {16'd0, e.exp[15:0]});
                chk("ovf", {31'd0, ovf}, {31'd0, e.exp[16]});
                chk("latency", cyc - e.acc, LAT);
            end
            if (spacing_chk && last_done >= 0) chk("done_spacing", cyc - last_done, 16);
            last_done = cyc;
        end
    end

    task automatic issue(input int v);
        @(negedge sclk);
        start  = 1'b1;
        bin_in = 14'(v);
        if (!busy) sbq.push_back('{model(v), cyc + 1});
        @(negedge sclk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge sclk);
            if (sbq.size() == 0 && !busy) break;
        end
        chk("idle_timeout", sbq.size(), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int vals[7] = '{0, 9999, 5, 1000, 10000, 16383, 77};
    int a;

    initial begin
        repeat (3) @(negedge sclk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        chk("rst_bcd", {16'd0, bcd_out}, 0);
        s_rst_n = 1'b1;

        // Basic conversion, busy timing and hold
        issue(1234);
        chk("busy_rise", {31'd0, busy}, 1);
        wait_idle();
        repeat (5) @(negedge sclk);
        chk("bcd_hold", {16'd0, bcd_out}, {16'd0, model(1234)});
        chk("done_low", {31'd0, done}, 0);

        // Range of in-range, boundary and overflow values
        foreach (vals[i]) begin
            issue(vals[i]);
            wait_idle();
        end

        // Starts during SHIFT and in the DONE-state cycle are ignored
        issue(1234);
        a = cyc;
        repeat (3) @(negedge sclk);
        start = 1'b1; bin_in = 14'd5678;
        @(negedge sclk);
        start = 1'b0;
        while (cyc < a + 14) @(negedge sclk);
        start = 1'b1; bin_in = 14'd5678;
        chk("busy_in_done", {31'd0, busy}, 1);
        @(negedge sclk);
        start = 1'b0;
        issue(5678);
        wait_idle();

        // Reset mid-conversion discards the result
        issue(4321);
        a = cyc;
        while (cyc < a + 7) @(negedge sclk);
        s_rst_n = 1'b0;
        #2;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_bcd", {16'd0, bcd_out}, 0);
        chk("midrst_ovf", {31'd0, ovf}, 0);
        chk("midrst_done", {31'd0, done}, 0);
        sbq.delete();
        repeat (3) @(negedge sclk);
        s_rst_n = 1'b1;
        repeat (20) @(negedge sclk);
        chk("midrst_quiet_bcd", {16'd0, bcd_out}, 0);
        issue(4321);
        wait_idle();

        // Start held high: back-to-back conversions every 16 cycles
        spacing_chk = 1'b1;
        last_done = -1;
        bin_in = 14'd250;
        for (int i = 0; i < 60; i++) begin
            @(negedge sclk);
            if (i == 59) start = 1'b0;
            else begin
                start = 1'b1;
                if (!busy) sbq.push_back('{model(250), cyc + 1});
            end
        end
        wait_idle();
        spacing_chk = 1'b0;

        repeat (3) @(negedge sclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/seg_bin2bcd.md
Name: seg_bin2bcd

Overview:
- Sequential binary-to-BCD converter (shift-add-3 / double dabble) that sits directly upstream of the 4-digit dynamic seg scan driver.
- Accepts a binary value with a start strobe and produces DIG_N packed BCD digits, digit 0 = units in bits [3:0].
- The scan driver consumes these digits as its per-position display numbers.
- Digit code 4'hF means "blank"; the scan driver already maps it to segments-off.

Parameters:
- BIN_W, 14, width of the binary input; also the number of shift iterations.
- DIG_N, 4, number of BCD digits output.
- MAX_VAL, 9999, largest convertible value; larger inputs flag overflow.

Ports:
- sclk  input  1  system clock, 50 MHz.
- s_rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  BIN_W  binary value; captured in the cycle start is accepted.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse; bcd_out/ovf are valid from this cycle on.
- bcd_out  output  4*DIG_N  packed BCD result, held until the next done.
- ovf  output  1  last conversion exceeded MAX_VAL; held with bcd_out.

Behaviour:
- Reset: all registers clear asynchronously when s_rst_n is low.
  - State is IDLE.
  - busy=0, done=0, ovf=0, bcd_out=0.
- One clock domain (sclk); reset is asynchronous and active-low (s_rst_n); no other clocks.
- FSM states and transitions:
  - IDLE: start=1 latches bin_in into the shift register, clears the BCD accumulator and iteration counter, compares bin_in against MAX_VAL into an ovf_pending flag, then goes to SHIFT.
  - SHIFT: each cycle, add 3 to every accumulator digit that is >=5, then shift {acc, sreg} left by 1. The counter increments; after the BIN_W-th shift, go to DONE.
  - DONE: register the result into bcd_out/ovf, pulse done=1, return to IDLE.
- busy=1 in SHIFT and DONE, 0 in IDLE.
- Latency: start sampled at edge N -> done=1 and new bcd_out in the cycle after edge N+BIN_W+1. That is 15 cycles for BIN_W=14. The cycle count is fixed and independent of the value.
- start while busy, including in the DONE cycle, is ignored, not queued. The earliest next acceptance is the first IDLE cycle after done.
- bin_in changes after acceptance have no effect.
- Overflow (bin_in > MAX_VAL):
  - The conversion still runs the full latency.
  - At DONE: bcd_out = all digits 4'hF (display blank), ovf=1.
- ovf=0 for any in-range result.
- Accumulator width is 4*DIG_N bits. The add-3 check applies to all digits every SHIFT cycle. No carry out of the top digit for in-range values.
- Reset mid-conversion: abort immediately and return to reset values. A pending result is discarded, with no done pulse.
- bcd_out and ovf change only at DONE or reset.

Optional Feature:
- Macro: SEG_LEAD_ZERO_BLANK_EN.
- Defined:
  - At DONE, each zero digit above the most-significant nonzero digit is replaced by 4'hF.
  - Digit 0 is never blanked, so value 0 gives 16'hFFF0 and 42 gives 16'hFF42.
  - No added latency; ovf behaviour is unchanged.
- Undefined: leading zeros are output as 0, so 42 gives 16'h0042.

Decomposition:
- Shared package seg_pkg holds:
  - DIGIT_BLANK = 4'hF.
  - FSM state typedef/encodings IDLE, SHIFT, DONE.
  - The BCD digit-width constant (4).
  - The SEG_NUM0..9/SEG_NONE patterns, shared with the scan driver.
- One natural sub-module: seg_bcd_add3, a combinational single-digit correction (in >= 5 ? in+3 : in), instantiated DIG_N times via generate.

Test Plan:
- Reset, then start with bin_in=1234 -> busy rises next cycle; done pulses exactly 15 cycles after acceptance; bcd_out=16'h1234, ovf=0; bcd_out held afterwards.
- bin_in=0, 9999, 5, 1000 sequentially -> 16'h0000, 16'h9999, 16'h0005, 16'h1000. With SEG_LEAD_ZERO_BLANK_EN: 16'hFFF0, 16'h9999, 16'hFFF5, 16'h1000.
- bin_in=10000, then 16383 -> bcd_out=16'hFFFF, ovf=1, same 15-cycle latency. A following 77 clears ovf, giving 16'h0077 (16'hFF77 with the macro).
- Start at 1234, then re-pulse start with 5678 during SHIFT and in the DONE cycle -> both ignored; result 16'h1234. A start one cycle after done converts 5678.
- Assert s_rst_n low at cycle 7 of a conversion of 4321 -> busy=0, bcd_out=0, ovf=0, no done pulse. After release, start 4321 -> 16'h4321 after 15 cycles.
- Hold start high continuously with bin_in=250 -> one conversion per 16 cycles; done spaced 16 cycles apart; bcd_out=16'h0250 every time.
